// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// The result is registered and held under a valid/ready handshake.
module alu_arbiter #(
   parameter int LEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [3:0]     req0_ctl,
   input  logic [LEN-1:0] req0_a,
   input  logic [LEN-1:0] req0_b,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [3:0]     req1_ctl,
   input  logic [LEN-1:0] req1_a,
   input  logic [LEN-1:0] req1_b,
   output logic [3:0]     alu_ctl,
   output logic [LEN-1:0] alu_a,
   output logic [LEN-1:0] alu_b,
   input  logic [LEN-1:0] alu_out,
   input  logic           alu_zero,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [LEN-1:0] rsp_data,
   output logic           rsp_zero
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e         state_q, state_d;
   logic           rsp_id_q, rsp_id_d;
   logic [LEN-1:0] rsp_data_q, rsp_data_d;
   logic           rsp_zero_q, rsp_zero_d;
   logic           rr_last_q, rr_last_d;

   logic gnt_vld;
   logic gnt_id;
   logic can_issue;
   logic accept;

   // Grant selection: a lone requester wins; on contention the one not served last
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (req0_valid && req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = ~rr_last_q;
      end else if (req0_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b0;
      end else if (req1_valid) begin
         gnt_vld = 1'b1;
         gnt_id  = 1'b1;
      end
   end

   // Handshake toward requesters; nothing is accepted while reset is asserted
   always_comb begin
      can_issue  = (state_q == EMPTY) | rsp_ready;
      req0_ready = can_issue & gnt_vld & ~gnt_id & rst_n;
      req1_ready = can_issue & gnt_vld & gnt_id & rst_n;
      accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   end

   // ALU operand mux: granted requester's controls, zeros when idle
   always_comb begin
      alu_ctl = '0;
      alu_a   = '0;
      alu_b   = '0;
      if (gnt_vld) begin
         alu_ctl = gnt_id ? req1_ctl : req0_ctl;
         alu_a   = gnt_id ? req1_a   : req0_a;
         alu_b   = gnt_id ? req1_b   : req0_b;
      end
   end

   // Next state: load on accept (even while retiring), otherwise drain on rsp_ready
   always_comb begin
      state_d    = state_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_zero_d = rsp_zero_q;
      rr_last_d  = rr_last_q;
      if (accept) begin
         state_d    = FULL;
         rsp_id_d   = gnt_id;
         rsp_data_d = alu_out;
         rsp_zero_d = alu_zero;
         rr_last_d  = gnt_id;
      end else if (rsp_ready) begin
         state_d    = EMPTY;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         rr_last_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_zero_q <= rsp_zero_d;
         rr_last_q  <= rr_last_d;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural MIPS ALU attached.
// Inputs driven 1 time unit after the rising edge, outputs sampled after settling.
module tb_alu_arbiter;

   localparam int LEN = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req0_valid, req0_ready;
   logic [3:0]     req0_ctl;
   logic [LEN-1:0] req0_a, req0_b;
   logic           req1_valid, req1_ready;
   logic [3:0]     req1_ctl;
   logic [LEN-1:0] req1_a, req1_b;
   logic [3:0]     alu_ctl;
   logic [LEN-1:0] alu_a, alu_b, alu_out;
   logic           alu_zero;
   logic           rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [LEN-1:0] rsp_data;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.LEN(LEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero)
   );

   // External MIPS ALU model
   always_comb begin
      case (alu_ctl)
         4'd0: alu_out = alu_a & alu_b;
         4'd1: alu_out = alu_a | alu_b;
         4'd2: alu_out = alu_a + alu_b;
         4'd3: alu_out = alu_a - alu_b;
         4'd4: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         4'd5: alu_out = ~(alu_a | alu_b);
         default: alu_out = '0;
      endcase
      alu_zero = (alu_out == '0);
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      next_cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b0; req1_ctl = 4'd0; req1_a = '0; req1_b = '0;
      next_cyc();
      next_cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
      total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", rsp_data); end
      total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL reset_id got=%b exp=0", rsp_id); end
      total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", rsp_zero); end
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
      rst_n = 1'b1;
      req0_valid = 1'b0;
      #1;
      total++; if ({alu_ctl, alu_a, alu_b} !== '0) begin bad++; $display("FAIL idle_alu got=%h/%h/%h exp=0", alu_ctl, alu_a, alu_b); end
   endtask

   task automatic test_single();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd5; req0_b = 32'd3;
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
      total++; if (alu_ctl !== 4'd2 || alu_a !== 32'd5) begin bad++; $display("FAIL single_alu got=%h/%h exp=2/5", alu_ctl, alu_a); end
      next_cyc();
      req0_valid = 1'b0;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
      total++; if (rsp_data !== 32'd8) begin bad++; $display("FAIL single_data got=%0d exp=8", rsp_data); end
      total++; if (rsp_id !== 1'b0) begin bad++; $display("FAIL single_id got=%b exp=0", rsp_id); end
      total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL single_zero got=%b exp=0", rsp_zero); end
      next_cyc();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [LEN-1:0] exp_d;
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_ctl = 4'd3; req1_a = 32'd9; req1_b = 32'd4;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL rr_grant%0d got=%b%b", i, req1_ready, req0_ready);
         end
         next_cyc();
         exp_d = (i % 2) ? 32'd5 : 32'd2;
         total++;
         if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 1'(i % 2)) begin
            bad++; $display("FAIL rr_rsp%0d got=%b/%0d/%b exp=1/%0d/%0d", i, rsp_valid, rsp_data, rsp_id, exp_d, i % 2);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      next_cyc();
   endtask

   task automatic test_stall();
      do_reset();
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_ctl = 4'd3; req1_a = 32'd7; req1_b = 32'd7;
      #1;
      total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b exp=1", req1_ready); end
      next_cyc();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
            bad++; $display("FAIL stall_hold%0d got=%b/%h/%b/%b exp=1/0/1/1", i, rsp_valid, rsp_data, rsp_zero, rsp_id);
         end
         total++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL stall_ready%0d got=%b%b exp=00", i, req1_ready, req0_ready);
         end
         next_cyc();
      end
      rsp_ready = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", req0_ready); end
      next_cyc();
      req0_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_id !== 1'b0) begin
         bad++; $display("FAIL stall_next got=%b/%0d/%b exp=1/2/0", rsp_valid, rsp_data, rsp_id);
      end
      next_cyc();
   endtask

   task automatic test_back_to_back();
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_ctl = 4'd4; req0_a = 32'd2; req0_b = 32'd9;
      next_cyc();
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin bad++; $display("FAIL b2b_slt got=%b/%h exp=1/1", rsp_valid, rsp_data); end
      req0_ctl = 4'd5; req0_a = 32'd0; req0_b = 32'd0;
      #1;
      total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", req0_ready); end
      next_cyc();
      req0_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_zero !== 1'b0) begin
         bad++; $display("FAIL b2b_nor got=%b/%h/%b exp=1/ffffffff/0", rsp_valid, rsp_data, rsp_zero);
      end
      next_cyc();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd5; req0_b = 32'd3;
      next_cyc();
      req0_valid = 1'b0;
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd8) begin bad++; $display("FAIL mid_held got=%b/%0d exp=1/8", rsp_valid, rsp_data); end
      rst_n = 1'b0;
      rsp_ready = 1'b1;
      req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd3; req1_b = 32'd3;
      #1;
      total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", req1_ready); end
      next_cyc();
      total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin bad++; $display("FAIL mid_clear got=%b/%h exp=0/0", rsp_valid, rsp_data); end
      rst_n = 1'b1;
      req0_valid = 1'b1;
      #1;
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL mid_prio got=%b%b exp=01", req1_ready, req0_ready);
      end
      next_cyc();
      total++; if (rsp_id !== 1'b0 || rsp_data !== 32'd8) begin bad++; $display("FAIL mid_first got=%b/%0d exp=0/8", rsp_id, rsp_data); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      next_cyc();
   endtask

   task automatic test_undef_ctl();
      do_reset();
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_ctl = 4'd7; req0_a = 32'h12; req0_b = 32'h34;
      #1;
      total++; if (alu_ctl !== 4'd7 || alu_b !== 32'h34) begin bad++; $display("FAIL undef_pass got=%h/%h exp=7/34", alu_ctl, alu_b); end
      next_cyc();
      req0_valid = 1'b0;
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0) begin
         bad++; $display("FAIL undef_rsp got=%b/%h/%b/%b exp=1/0/1/0", rsp_valid, rsp_data, rsp_zero, rsp_id);
      end
      next_cyc();
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_undef_ctl();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
